dram_sequencer: RTL and testbench

- Single-clock DRAM timing controller for the Zorro II FastRAM array: 4 RAS banks (2MB each) with shared UCAS/LCAS.
- Arbitrates between bus access requests from the address-decode/autoconfig logic and CAS-before-RAS refresh.
- Generates registered RAS/CAS/WE/row-column mux select and the DTACK enable.
- Sits between the address decode (ram_addrmatched qualified with ASn) and the DRAM pins/MADDR mux.

---
 rtl/dram_pkg.sv | 41 ++++
 rtl/dram_refresh_timer.sv | 54 +++++
 rtl/dram_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dram_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
//==============================================================
// dram_pkg: shared types and constants for the FastRAM sequencer
// Rev 1.0
//==============================================================
`default_nettype none
`timescale 1ns/1ps

package dram_pkg;

   localparam int DEFAULT_REFRESH_INTERVAL = 108;   // 15.2us at 7.09MHz
   localparam int DEFAULT_MAX_OWED         = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACC_RAS  = 3'd1,
      ST_ACC_CAS  = 3'd2,
      ST_PRECHG   = 3'd3,
      ST_REF_CAS  = 3'd4,
      ST_REF_RAS  = 3'd5,
      ST_REF_HOLD = 3'd6,
      ST_REF_PRE  = 3'd7
   } state_t;

   localparam logic [3:0] RAS_NONE = 4'hF;
   localparam logic [3:0] RAS_ALL  = 4'h0;

   // ADDR[22:21] = 01/10/11/00 selects RAS1..RAS4 (bit0..bit3)
   function automatic logic [3:0] bank_ras_n(input logic [1:0] bank);
      logic [3:0] ras_n;
      case (bank)
         2'b01:   ras_n = 4'b1110;
         2'b10:   ras_n = 4'b1101;
         2'b11:   ras_n = 4'b1011;
         default: ras_n = 4'b0111;
      endcase
      return ras_n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dram_refresh_timer.sv
//==============================================================
// dram_refresh_timer: refresh interval counter and saturating owed count
// Rev 1.0
//==============================================================
`default_nettype none
`timescale 1ns/1ps

module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
   parameter int MAX_OWED         = DEFAULT_MAX_OWED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dec,
   output logic [2:0] owed,
   output logic       owed_full
);

   localparam int                 TIMER_W  = $clog2(REFRESH_INTERVAL);
   localparam logic [TIMER_W-1:0] RELOAD   = TIMER_W'(REFRESH_INTERVAL - 1);
   localparam logic [2:0]         OWED_MAX = 3'(MAX_OWED);

   logic [TIMER_W-1:0] timer;
   logic               tick;

   assign tick      = (timer == '0);
   assign owed_full = (owed == OWED_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= RELOAD;
      end else if (tick) begin
         timer <= RELOAD;
      end else begin
         timer <= timer - TIMER_W'(1);
      end
   end

   // A tick and a completed refresh in the same cycle cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owed <= 3'd0;
      end else if (tick && !dec && (owed != OWED_MAX)) begin
         owed <= owed + 3'd1;
      end else if (dec && !tick && (owed != 3'd0)) begin
         owed <= owed - 3'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dram_sequencer.sv
//==============================================================
// dram_sequencer: Zorro II FastRAM RAS/CAS timing and refresh arbiter
// Rev 1.0
//==============================================================
`default_nettype none
`timescale 1ns/1ps

module dram_sequencer
   import dram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
   parameter int MAX_OWED         = DEFAULT_MAX_OWED
) (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic       REQ,
   input  logic [1:0] BANK,
   input  logic       UDSn,
   input  logic       LDSn,
   input  logic       RWn,
   output logic [3:0] RASn,
   output logic       UCASn,
   output logic       LCASn,
   output logic       MEMWn,
   output logic       MUX_COL,
   output logic       ACK,
   output logic       BUSY_REF
);

   state_t     state, state_nxt;
   logic       req_q;
   logic [1:0] lat_bank, lat_bank_nxt;
   logic       lat_rw, lat_rw_nxt;
   logic       lat_uds, lat_uds_nxt;
   logic       lat_lds, lat_lds_nxt;
   logic       ref_done;
   logic [2:0] owed;
   logic       owed_full;

   logic [3:0] ras_nxt;
   logic       ucas_nxt, lcas_nxt, memw_nxt, mux_nxt, ack_nxt, busy_nxt;

   dram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL),
      .MAX_OWED         (MAX_OWED)
   ) u_timer (
      .clk       (CLK),
      .rst_n     (RESETn),
      .dec       (ref_done),
      .owed      (owed),
      .owed_full (owed_full)
   );

   // Next state and latched access attributes
   always_comb begin
      state_nxt    = state;
      lat_bank_nxt = lat_bank;
      lat_rw_nxt   = lat_rw;
      lat_uds_nxt  = lat_uds;
      lat_lds_nxt  = lat_lds;
      ref_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (owed_full) begin
               state_nxt = ST_REF_CAS;
            end else if (req_q) begin
               state_nxt    = ST_ACC_RAS;
               lat_bank_nxt = BANK;
               lat_rw_nxt   = RWn;
               lat_uds_nxt  = UDSn;
               lat_lds_nxt  = LDSn;
            end else if (owed != 3'd0) begin
               state_nxt = ST_REF_CAS;
            end
         end
         ST_ACC_RAS:  state_nxt = req_q ? ST_ACC_CAS : ST_PRECHG;
         ST_ACC_CAS:  state_nxt = req_q ? ST_ACC_CAS : ST_PRECHG;
         ST_PRECHG:   state_nxt = ST_IDLE;
         ST_REF_CAS:  state_nxt = ST_REF_RAS;
         ST_REF_RAS:  state_nxt = ST_REF_HOLD;
         ST_REF_HOLD: state_nxt = ST_REF_PRE;
         ST_REF_PRE: begin
            state_nxt = ST_IDLE;
            ref_done  = 1'b1;
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the pins come straight off flops
   always_comb begin
      ras_nxt  = RAS_NONE;
      ucas_nxt = 1'b1;
      lcas_nxt = 1'b1;
      memw_nxt = 1'b1;
      mux_nxt  = 1'b0;
      ack_nxt  = 1'b0;
      busy_nxt = 1'b0;
      case (state_nxt)
         ST_ACC_RAS: begin
            ras_nxt = bank_ras_n(lat_bank_nxt);
         end
         ST_ACC_CAS: begin
            ras_nxt  = bank_ras_n(lat_bank_nxt);
            ucas_nxt = lat_uds_nxt;
            lcas_nxt = lat_lds_nxt;
            memw_nxt = lat_rw_nxt;
            mux_nxt  = 1'b1;
            ack_nxt  = 1'b1;
         end
         ST_REF_CAS: begin
            ucas_nxt = 1'b0;
            lcas_nxt = 1'b0;
            busy_nxt = 1'b1;
         end
         ST_REF_RAS, ST_REF_HOLD: begin
            ras_nxt  = RAS_ALL;
            ucas_nxt = 1'b0;
            lcas_nxt = 1'b0;
            busy_nxt = 1'b1;
         end
         ST_REF_PRE: begin
            busy_nxt = 1'b1;
         end
         default: begin
            ras_nxt = RAS_NONE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state    <= ST_IDLE;
         req_q    <= 1'b0;
         lat_bank <= 2'b00;
         lat_rw   <= 1'b1;
         lat_uds  <= 1'b1;
         lat_lds  <= 1'b1;
         RASn     <= RAS_NONE;
         UCASn    <= 1'b1;
         LCASn    <= 1'b1;
         MEMWn    <= 1'b1;
         MUX_COL  <= 1'b0;
         ACK      <= 1'b0;
         BUSY_REF <= 1'b0;
      end else begin
         state    <= state_nxt;
         req_q    <= REQ;
         lat_bank <= lat_bank_nxt;
         lat_rw   <= lat_rw_nxt;
         lat_uds  <= lat_uds_nxt;
         lat_lds  <= lat_lds_nxt;
         RASn     <= ras_nxt;
         UCASn    <= ucas_nxt;
         LCASn    <= lcas_nxt;
         MEMWn    <= memw_nxt;
         MUX_COL  <= mux_nxt;
         ACK      <= ack_nxt;
         BUSY_REF <= busy_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dram_sequencer.sv
//==============================================================
// tb_dram_sequencer: directed and random checks against a cycle-queue model
// Rev 1.0
//==============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dram_sequencer;
   import dram_pkg::*;

   localparam int RI = 108;
   localparam int MO = 4;

   logic       CLK = 1'b0;
   logic       RESETn = 1'b0;
   logic       REQ = 1'b0;
   logic [1:0] BANK = 2'b00;
   logic       UDSn = 1'b1;
   logic       LDSn = 1'b1;
   logic       RWn = 1'b1;
   logic [3:0] RASn;
   logic       UCASn, LCASn, MEMWn, MUX_COL, ACK, BUSY_REF;

   dram_sequencer dut (
      .CLK(CLK), .RESETn(RESETn), .REQ(REQ), .BANK(BANK), .UDSn(UDSn),
      .LDSn(LDSn), .RWn(RWn), .RASn(RASn), .UCASn(UCASn), .LCASn(LCASn),
      .MEMWn(MEMWn), .MUX_COL(MUX_COL), .ACK(ACK), .BUSY_REF(BUSY_REF)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] ras;
      logic ucas, lcas, memw, mux, ack, busy;
      logic dec;
   } vec_t;

   // Model: pending fixed-output cycles in a queue, plus access bookkeeping
   vec_t q[$];
   vec_t exp_v;
   int   tmr, own, acc, l_bank;
   bit   m_req_q, l_rw, l_uds, l_lds;

   function automatic vec_t mk(logic [3:0] ras, logic u, logic l, logic w,
                               logic m, logic a, logic b, logic d);
      vec_t v;
      v = '{ras, u, l, w, m, a, b, d};
      return v;
   endfunction

   function automatic logic [3:0] ras_of(int b);
      logic [3:0] one;
      one = 4'b0001;
      return 4'hF & ~(one << ((b + 3) % 4));
   endfunction

   task automatic model_reset();
      tmr = RI - 1; own = 0; acc = 0; m_req_q = 0;
      q.delete();
      exp_v = mk(4'hF, 1, 1, 1, 0, 0, 0, 0);
   endtask

   task automatic start_refresh();
      exp_v = mk(4'hF, 0, 0, 1, 0, 0, 1, 0);
      q.push_back(mk(4'h0, 0, 0, 1, 0, 0, 1, 0));
      q.push_back(mk(4'h0, 0, 0, 1, 0, 0, 1, 0));
      q.push_back(mk(4'hF, 1, 1, 1, 0, 0, 1, 0));
      q.push_back(mk(4'hF, 1, 1, 1, 0, 0, 0, 1));
   endtask

   task automatic model_edge();
      bit inc, dec;
      dec = 0;
      if (q.size() > 0) begin
         exp_v = q.pop_front();
         dec = exp_v.dec;
      end else if (acc != 0) begin
         if (m_req_q) begin
            acc = 2;
            exp_v = mk(ras_of(l_bank), l_uds, l_lds, l_rw, 1, 1, 0, 0);
         end else begin
            acc = 0;
            exp_v = mk(4'hF, 1, 1, 1, 0, 0, 0, 0);
            q.push_back(mk(4'hF, 1, 1, 1, 0, 0, 0, 0));
         end
      end else if (own == MO || (!m_req_q && own > 0)) begin
         start_refresh();
      end else if (m_req_q) begin
         l_bank = int'(BANK); l_rw = RWn; l_uds = UDSn; l_lds = LDSn;
         acc = 1;
         exp_v = mk(ras_of(l_bank), 1, 1, 1, 0, 0, 0, 0);
      end else begin
         exp_v = mk(4'hF, 1, 1, 1, 0, 0, 0, 0);
      end
      inc = (tmr == 0);
      tmr = inc ? RI - 1 : tmr - 1;
      if (inc && !dec && own < MO) own++;
      else if (dec && !inc && own > 0) own--;
      m_req_q = REQ;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [15:0] pins();
      return 16'({RASn, UCASn, LCASn, MEMWn, MUX_COL, ACK, BUSY_REF});
   endfunction

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      chk("outputs", pins(), 16'({exp_v.ras, exp_v.ucas, exp_v.lcas, exp_v.memw,
                                  exp_v.mux, exp_v.ack, exp_v.busy}));
      chk("owed", 16'(dut.u_timer.owed), 16'(own));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pins"}, pins(), 16'({4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      chk({tag, "_state"}, 16'(dut.state), 16'(ST_IDLE));
      chk({tag, "_owed"}, 16'(dut.u_timer.owed), 16'd0);
   endtask

   task automatic mid_reset(input string tag);
      #2 RESETn = 1'b0;
      #1 chk_reset(tag);
      model_reset();
      REQ = 1'b0;
      #2 RESETn = 1'b1;
   endtask

   initial begin
      model_reset();
      #17 chk_reset("reset");
      @(negedge CLK);
      #2 RESETn = 1'b1;

      // First refresh interval expires with no traffic
      steps(RI);
      chk("owed_after_interval", 16'(dut.u_timer.owed), 16'd1);
      step();
      chk("ref_cas", 16'({RASn, UCASn, LCASn, MEMWn}), 16'b1111_0_0_1);
      steps(4);
      chk("owed_after_ref", 16'(dut.u_timer.owed), 16'd0);

      // Read, bank 2, upper byte
      BANK = 2'b10; RWn = 1'b1; UDSn = 1'b0; LDSn = 1'b1; REQ = 1'b1;
      step(); step();
      chk("read_ras", 16'(RASn), 16'(4'b1101));
      step();
      chk("read_cas", 16'({MUX_COL, UCASn, LCASn, ACK}), 16'(4'b1011));
      step();
      REQ = 1'b0;
      steps(4);

      // Word write, bank 4
      BANK = 2'b00; RWn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; REQ = 1'b1;
      steps(3);
      chk("write_cas", 16'({RASn, MEMWn, UCASn, LCASn}), 16'(7'b0111_000));
      REQ = 1'b0;
      steps(4);

      // Back-to-back requests
      for (int i = 0; i < 4; i++) begin
         BANK = 2'(i); RWn = 1'(i & 1); UDSn = 1'b0; LDSn = 1'(i >> 1); REQ = 1'b1;
         steps(3);
         REQ = 1'b0;
         step();
      end
      steps(4);

      // Long hold saturates owed; a short drop lets refresh win before the access
      REQ = 1'b1; RWn = 1'b1; BANK = 2'b01;
      steps(500);
      chk("owed_saturated", 16'(dut.u_timer.owed), 16'd4);
      REQ = 1'b0; step();
      REQ = 1'b1; steps(14);
      REQ = 1'b0; steps(30);
      chk("owed_drained", 16'(dut.u_timer.owed), 16'd0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         REQ = 1'b0;
         steps(int'($urandom_range(0, 6)));
         BANK = 2'($urandom_range(0, 3));
         RWn  = 1'($urandom_range(0, 1));
         UDSn = 1'($urandom_range(0, 1));
         LDSn = 1'($urandom_range(0, 1));
         REQ  = 1'b1;
         steps(int'($urandom_range(1, 8)));
      end
      REQ = 1'b0;
      steps(20);

      // Asynchronous reset in the middle of an access
      BANK = 2'b11; RWn = 1'b0; UDSn = 1'b0; LDSn = 1'b1; REQ = 1'b1;
      steps(3);
      chk("pre_reset_ack", 16'(ACK), 16'd1);
      mid_reset("reset_in_cas");

      // Asynchronous reset in the middle of a refresh
      steps(RI + 2);
      chk("pre_reset_ref_ras", 16'(RASn), 16'd0);
      mid_reset("reset_in_ref");
      steps(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
